// File: rtl/sha_pkg.sv
// Shared types and constants for the SHA-2 message padder.
// FSM states and default SHA-256 geometry.
package sha_pkg;

  typedef enum logic [1:0] {
    ABSORB,
    PAD80,
    PADZ,
    LEN
  } pad_state_e;

  localparam logic [7:0] PAD_BYTE = 8'h80;
  localparam int SHA256_BLOCK_WORDS = 16;
  localparam int SHA256_LEN_W = 64;

endpackage

// File: rtl/sha_word_fifo.sv
// Output word FIFO for the SHA-2 padder.
// Push and pop in the same cycle are both taken, even when full.
module sha_word_fifo #(
  parameter int W     = 37,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wptr;
  logic [AW:0]  rptr;
  logic         do_push;
  logic         do_pop;

  assign empty   = (wptr == rptr);
  assign full    = (wptr[AW] != rptr[AW]) &&
                   (wptr[AW-1:0] == rptr[AW-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = empty ? '0 : mem[rptr[AW-1:0]];

  // Read/write pointers; reset flushes all contents.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
    end
  end

  // Storage array, written on accepted pushes only.
  always_ff @(posedge clk) begin
    if (do_push) mem[wptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/sha_msg_padder.sv
// SHA-2 message padder: bytes in, padded big-endian words out.
// One byte per cycle enters the word shifter; full words queue in a FIFO.
module sha_msg_padder
  import sha_pkg::*;
#(
  parameter int WORD_W      = 32,
  parameter int BLOCK_WORDS = SHA256_BLOCK_WORDS,
  parameter int LEN_W       = SHA256_LEN_W,
  parameter int OUT_DEPTH   = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [7:0]                     byte_in,
  input  logic                           byte_dv_in,
  input  logic                           eom_in,
  output logic                           byte_ready_out,
  output logic [WORD_W-1:0]              data_out,
  output logic                           data_valid_out,
  input  logic                           data_ready_in,
  output logic [$clog2(BLOCK_WORDS)-1:0] word_idx_out,
  output logic                           block_last_out,
  output logic                           busy_out,
  output logic                           err_ovf_out
);

  localparam int BPW     = WORD_W / 8;
  localparam int BB      = BLOCK_WORDS * BPW;
  localparam int LEN_B   = LEN_W / 8;
  localparam int LEN_POS = BB - LEN_B;
  localparam int IDX_W   = $clog2(BLOCK_WORDS);
  localparam int POS_W   = $clog2(BB);
  localparam int BSEL_W  = $clog2(BPW);
  localparam int LC_W    = $clog2(LEN_B);
  localparam int FW      = WORD_W + IDX_W + 1;

  pad_state_e         state;
  pad_state_e         state_nx;
  logic [WORD_W-1:0]  shreg;
  logic [WORD_W-1:0]  word_nx;
  logic [POS_W-1:0]   byte_pos;
  logic [POS_W-1:0]   pos_inc;
  logic [LEN_W-1:0]   bit_len;
  logic [LC_W-1:0]    len_cnt;
  logic [7:0]         len_byte;
  logic               rdy_en;
  logic               err;
  logic               pend;
  logic [IDX_W-1:0]   pend_idx;
  logic               pend_last;
  logic               ins_en;
  logic [7:0]         ins_byte;
  logic               last_w;
  logic               word_end;
  logic               push_ok;
  logic               can_ins;
  logic               acc_byte;
  logic               acc_eom;
  logic               fifo_full;
  logic               fifo_empty;
  logic [FW-1:0]      fifo_dout;

  assign pos_inc  = byte_pos + 1'b1;
  assign word_end = (byte_pos[BSEL_W-1:0] == BSEL_W'(BPW - 1));
  assign push_ok  = !fifo_full || data_ready_in;
  assign can_ins  = !pend || push_ok;
  assign len_byte = bit_len[(LEN_B - 1 - int'(len_cnt)) * 8 +: 8];
  assign word_nx  = {shreg[WORD_W-9:0], ins_byte};

  assign byte_ready_out = rdy_en && (state == ABSORB) && !fifo_full;
  assign acc_byte       = byte_dv_in && byte_ready_out;
  assign acc_eom        = eom_in && byte_ready_out;

  // Next state and the byte lane source for this cycle.
  always_comb begin
    state_nx = state;
    ins_en   = 1'b0;
    ins_byte = '0;
    last_w   = 1'b0;
    unique case (state)
      ABSORB: begin
        ins_en   = acc_byte;
        ins_byte = byte_in;
        if (acc_eom) state_nx = PAD80;
      end
      PAD80: begin
        if (can_ins) begin
          ins_en   = 1'b1;
          ins_byte = PAD_BYTE;
          state_nx = (pos_inc == POS_W'(LEN_POS)) ? LEN : PADZ;
        end
      end
      PADZ: begin
        if (can_ins) begin
          ins_en = 1'b1;
          if (pos_inc == POS_W'(LEN_POS)) state_nx = LEN;
        end
      end
      LEN: begin
        if (can_ins) begin
          ins_en   = 1'b1;
          ins_byte = len_byte;
          if (len_cnt == LC_W'(LEN_B - 1)) begin
            last_w   = 1'b1;
            state_nx = ABSORB;
          end
        end
      end
      default: state_nx = ABSORB;
    endcase
  end

  // Datapath state: shifter, counters, pending word, overflow flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ABSORB;
      shreg     <= '0;
      byte_pos  <= '0;
      bit_len   <= '0;
      len_cnt   <= '0;
      rdy_en    <= 1'b0;
      err       <= 1'b0;
      pend      <= 1'b0;
      pend_idx  <= '0;
      pend_last <= 1'b0;
    end else begin
      rdy_en <= 1'b1;
      state  <= state_nx;
      if (ins_en) begin
        shreg    <= word_nx;
        byte_pos <= pos_inc;
      end
      if (acc_byte) bit_len <= bit_len + LEN_W'(8);
      if (ins_en && state == LEN) len_cnt <= len_cnt + 1'b1;
      if (last_w) begin
        bit_len  <= '0;
        byte_pos <= '0;
        len_cnt  <= '0;
      end
      if (ins_en && word_end) begin
        pend      <= 1'b1;
        pend_idx  <= byte_pos[POS_W-1:BSEL_W];
        pend_last <= last_w;
      end else if (pend && push_ok) begin
        pend <= 1'b0;
      end
      if ((byte_dv_in || eom_in) && !byte_ready_out) err <= 1'b1;
    end
  end

  sha_word_fifo #(
    .W    (FW),
    .DEPTH(OUT_DEPTH)
  ) u_fifo (
    .clk  (clk),
    .rst  (rst),
    .push (pend),
    .din  ({pend_last, pend_idx, shreg}),
    .pop  (data_ready_in),
    .dout (fifo_dout),
    .full (fifo_full),
    .empty(fifo_empty)
  );

  assign data_valid_out = !fifo_empty;
  assign data_out       = fifo_dout[WORD_W-1:0];
  assign word_idx_out   = fifo_dout[WORD_W +: IDX_W];
  assign block_last_out = fifo_dout[FW-1];
  assign err_ovf_out    = err;
  assign busy_out       = (state != ABSORB) || (|bit_len) || (|byte_pos) ||
                          pend || !fifo_empty;

endmodule

// File: tb/tb_sha_msg_padder.sv
// Directed bench for sha_msg_padder (32-bit and 64-bit word builds).
// Expected words are hand-computed SHA-2 padding results.
module tb_sha_msg_padder;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [7:0]  b32, b64;
  logic        dv32, eom32, rdy32, v32, rin32, last32, busy32, err32;
  logic        dv64, eom64, rdy64, v64, rin64, last64, busy64, err64;
  logic [31:0] d32;
  logic [63:0] d64;
  logic [3:0]  idx32, idx64;

  sha_msg_padder dut (
    .clk(clk), .rst(rst), .byte_in(b32), .byte_dv_in(dv32),
    .eom_in(eom32), .byte_ready_out(rdy32), .data_out(d32),
    .data_valid_out(v32), .data_ready_in(rin32),
    .word_idx_out(idx32), .block_last_out(last32),
    .busy_out(busy32), .err_ovf_out(err32)
  );

  sha_msg_padder #(.WORD_W(64), .LEN_W(128)) dut64 (
    .clk(clk), .rst(rst), .byte_in(b64), .byte_dv_in(dv64),
    .eom_in(eom64), .byte_ready_out(rdy64), .data_out(d64),
    .data_valid_out(v64), .data_ready_in(rin64),
    .word_idx_out(idx64), .block_last_out(last64),
    .busy_out(busy64), .err_ovf_out(err64)
  );

  int           n_chk = 0;
  int           n_err = 0;
  string        scen;
  logic [127:0] got32[$];
  logic [127:0] got64[$];
  logic [127:0] expq[$];
  logic [7:0]   tx_q[$];

  task automatic check(input string tag, input logic [127:0] got,
                       input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s/%s: got %0h expected %0h", scen, tag, got, exp);
    end
  endtask

  function automatic logic [127:0] pk(input logic [63:0] d,
                                      input logic [3:0] i, input logic l);
    return {55'b0, d, 4'b0, i, l};
  endfunction

  always @(negedge clk) begin
    if (!rst) begin
      if (v32 && rin32) got32.push_back(pk(64'(d32), idx32, last32));
      if (v64 && rin64) got64.push_back(pk(d64, idx64, last64));
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_rdy(input bit w64);
    int t = 0;
    while (!(w64 ? rdy64 : rdy32) && t < 300) begin
      cyc(1);
      t++;
    end
    if (t >= 300) check("rdy_timeout", w64 ? rdy64 : rdy32, 1);
  endtask

  // mode 0: eom with last byte, 1: eom alone after bytes, 2: no eom
  task automatic send(input bit w64, input int mode);
    bit e;
    for (int i = 0; i < tx_q.size(); i++) begin
      wait_rdy(w64);
      e = (mode == 0) && (i == tx_q.size() - 1);
      if (w64) begin
        b64 = tx_q[i]; dv64 = 1'b1; eom64 = e;
      end else begin
        b32 = tx_q[i]; dv32 = 1'b1; eom32 = e;
      end
      cyc(1);
      dv32 = 1'b0; eom32 = 1'b0; dv64 = 1'b0; eom64 = 1'b0;
    end
    if (mode == 1 || (mode == 0 && tx_q.size() == 0)) begin
      wait_rdy(w64);
      if (w64) eom64 = 1'b1;
      else eom32 = 1'b1;
      cyc(1);
      eom32 = 1'b0; eom64 = 1'b0;
    end
  endtask

  task automatic wait_words(input bit w64, input int n);
    int t = 0;
    while ((w64 ? got64.size() : got32.size()) < n && t < 3000) begin
      cyc(1);
      t++;
    end
    cyc(8);
    check("word_count", w64 ? got64.size() : got32.size(), n);
  endtask

  task automatic exp_zero(input int n);
    expq.delete();
    for (int i = 0; i < n; i++)
      expq.push_back(pk(64'h0, 4'(i % 16), i == n - 1));
  endtask

  task automatic exp_set(input int i, input logic [63:0] d);
    logic [127:0] t;
    t = expq[i];
    t[72:9] = d;
    expq[i] = t;
  endtask

  task automatic compare(input bit w64);
    int n;
    n = w64 ? got64.size() : got32.size();
    for (int i = 0; i < expq.size(); i++)
      if (i < n)
        check($sformatf("w%0d", i), w64 ? got64[i] : got32[i], expq[i]);
  endtask

  task automatic abc_exp(input bit w64);
    exp_zero(16);
    exp_set(0, w64 ? 64'h6162638000000000 : 64'h61626380);
    exp_set(15, 64'h18);
  endtask

  task automatic load_abc();
    tx_q = '{8'h61, 8'h62, 8'h63};
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int t;
    b32 = '0; dv32 = 1'b0; eom32 = 1'b0; rin32 = 1'b1;
    b64 = '0; dv64 = 1'b0; eom64 = 1'b0; rin64 = 1'b1;

    scen = "reset";
    cyc(3);
    check("valid", v32, 0);
    check("ready", rdy32, 0);
    check("busy", busy32, 0);
    check("err", err32, 0);
    check("data", d32, 0);
    check("last", last32, 0);
    rst = 1'b0;
    check("ready_rel", rdy32, 0);
    cyc(1);
    check("ready_1", rdy32, 1);
    check("ready64_1", rdy64, 1);

    scen = "abc";
    got32.delete();
    load_abc();
    send(0, 0);
    check("lat_n", v32, 0);
    cyc(1);
    check("lat_n1", v32, 0);
    cyc(1);
    check("lat_n2", v32, 1);
    check("busy", busy32, 1);
    wait_words(0, 16);
    abc_exp(0);
    compare(0);
    check("idle", busy32, 0);

    scen = "empty";
    got32.delete();
    tx_q.delete();
    send(0, 1);
    wait_words(0, 16);
    exp_zero(16);
    exp_set(0, 64'h80000000);
    compare(0);

    scen = "a56";
    got32.delete();
    tx_q.delete();
    for (int i = 0; i < 56; i++) tx_q.push_back(8'h61);
    send(0, 0);
    wait_words(0, 32);
    exp_zero(32);
    for (int i = 0; i < 14; i++) exp_set(i, 64'h61616161);
    exp_set(14, 64'h80000000);
    exp_set(31, 64'h1C0);
    compare(0);

    scen = "stall";
    got32.delete();
    rin32 = 1'b0;
    load_abc();
    send(0, 0);
    t = 0;
    while (!v32 && t < 50) begin
      cyc(1);
      t++;
    end
    check("valid", v32, 1);
    for (int k = 0; k < 20; k++) begin
      if (k == 0 || k == 10 || k == 19) begin
        check($sformatf("hold_d%0d", k), d32, 32'h61626380);
        check($sformatf("hold_i%0d", k), idx32, 0);
      end
      cyc(1);
    end
    check("ready_stall", rdy32, 0);
    check("busy_stall", busy32, 1);
    check("none_taken", got32.size(), 0);
    rin32 = 1'b1;
    wait_words(0, 16);
    abc_exp(0);
    compare(0);

    scen = "ovf";
    got32.delete();
    load_abc();
    send(0, 0);
    cyc(10);
    check("err_pre", err32, 0);
    b32 = 8'hff;
    dv32 = 1'b1;
    cyc(1);
    dv32 = 1'b0;
    check("err_set", err32, 1);
    wait_words(0, 16);
    abc_exp(0);
    compare(0);
    check("err_sticky", err32, 1);

    scen = "abort";
    got32.delete();
    rin32 = 1'b0;
    tx_q.delete();
    for (int i = 0; i < 10; i++) tx_q.push_back(8'(8'h30 + i));
    send(0, 2);
    cyc(1);
    check("busy_pre", busy32, 1);
    rst = 1'b1;
    #1;
    check("valid", v32, 0);
    check("data", d32, 0);
    check("ready", rdy32, 0);
    check("busy", busy32, 0);
    check("err", err32, 0);
    cyc(2);
    rst = 1'b0;
    rin32 = 1'b1;
    cyc(30);
    check("no_words", got32.size(), 0);
    load_abc();
    send(0, 0);
    wait_words(0, 16);
    abc_exp(0);
    compare(0);

    scen = "w64";
    got64.delete();
    load_abc();
    send(1, 0);
    wait_words(1, 16);
    abc_exp(1);
    compare(1);
    check("idle64", busy64, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
